// File: rtl/memory_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single word-wide memory bus.
// Handles byte/half/word lane steering, sign extension, illegal-access errors and ack timeout.
module memory_arbiter #(
  parameter int MEMORY_DEPTH = 32,
  parameter int MEMORY_WIDTH = 32,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [MEMORY_DEPTH-1:0] if_addr,
  output logic                    if_ready,
  output logic                    if_rvalid,
  output logic [MEMORY_WIDTH-1:0] if_rdata,
  output logic                    if_err,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [1:0]              d_width,
  input  logic                    d_signed,
  input  logic [MEMORY_DEPTH-1:0] d_addr,
  input  logic [MEMORY_WIDTH-1:0] d_wdata,
  output logic                    d_ready,
  output logic                    d_rvalid,
  output logic [MEMORY_WIDTH-1:0] d_rdata,
  output logic                    d_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [MEMORY_DEPTH-1:0] mem_addr,
  output logic [3:0]              mem_be,
  output logic [MEMORY_WIDTH-1:0] mem_wdata,
  input  logic                    mem_ack,
  input  logic [MEMORY_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, ERR_D} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_last_if;
  logic [CW-1:0]           r_wait;
  logic [1:0]              r_off;
  logic [1:0]              r_width;
  logic                    r_signed;
  logic                    r_mem_req;
  logic                    r_mem_we;
  logic [MEMORY_DEPTH-1:0] r_mem_addr;
  logic [3:0]              r_mem_be;
  logic [MEMORY_WIDTH-1:0] r_mem_wdata;
  logic                    r_if_rvalid;
  logic [MEMORY_WIDTH-1:0] r_if_rdata;
  logic                    r_if_err;
  logic                    r_d_rvalid;
  logic [MEMORY_WIDTH-1:0] r_d_rdata;
  logic                    r_d_err;

  logic                    w_gnt_if;
  logic                    w_gnt_d;
  logic                    w_done;
  logic                    w_timeout;
  logic                    w_d_legal;
  logic [MEMORY_DEPTH-1:0] w_acc_addr;
  logic [1:0]              w_off;
  logic [3:0]              w_be;
  logic [MEMORY_WIDTH-1:0] w_wdata;
  logic [MEMORY_WIDTH-1:0] w_shift;
  logic [MEMORY_WIDTH-1:0] w_load;

  assign w_done    = r_mem_req & mem_ack;
  assign w_timeout = r_mem_req & ~mem_ack & (r_wait == CW'(TIMEOUT - 1));

  assign w_acc_addr = w_gnt_if ? if_addr : d_addr;
  assign w_off      = w_acc_addr[1:0];
  assign w_d_legal  = (d_width != 2'd0) && !(d_width == 2'd2 && d_addr[0]) &&
                      !(d_width == 2'd3 && d_addr[1:0] != 2'b00);

  // r_last_if=1 means the data side is favoured on the next contention
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_if    = 1'b0;
    w_gnt_d     = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_n) begin
          if (d_req && (!if_req || r_last_if)) w_gnt_d  = 1'b1;
          else if (if_req)                     w_gnt_if = 1'b1;
        end
        if (w_gnt_d)       w_state_nxt = w_d_legal ? BUSY_D : ERR_D;
        else if (w_gnt_if) w_state_nxt = BUSY_IF;
      end
      BUSY_IF, BUSY_D: if (w_done || w_timeout) w_state_nxt = IDLE;
      ERR_D:           w_state_nxt = IDLE;
      default:         w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = '0;
    if (w_gnt_d) begin
      case (d_width)
        2'd1:    w_be = 4'b0001 << w_off;
        2'd2:    w_be = 4'b0011 << w_off;
        default: w_be = 4'b1111;
      endcase
      if (d_we) begin
        case (d_width)
          2'd1:    w_wdata = {24'b0, d_wdata[7:0]} << {w_off, 3'b000};
          2'd2:    w_wdata = {16'b0, d_wdata[15:0]} << {w_off, 3'b000};
          default: w_wdata = d_wdata;
        endcase
      end
    end
  end

  always_comb begin
    w_shift = mem_rdata >> {r_off, 3'b000};
    w_load  = w_shift;
    case (r_width)
      2'd1:    w_load = {{24{r_signed & w_shift[7]}}, w_shift[7:0]};
      2'd2:    w_load = {{16{r_signed & w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last_if <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt_if || w_gnt_d) r_last_if <= w_gnt_if;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait      <= '0;
      r_off       <= '0;
      r_width     <= '0;
      r_signed    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_if_err    <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
      r_d_err     <= 1'b0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      if (w_gnt_if || w_gnt_d) begin
        r_wait   <= '0;
        r_off    <= w_off;
        r_width  <= w_gnt_d ? d_width : 2'd3;
        r_signed <= w_gnt_d & d_signed;
        if (w_gnt_d && !w_d_legal) begin
          r_d_rvalid <= 1'b1;
          r_d_err    <= 1'b1;
          r_d_rdata  <= '0;
        end else begin
          r_mem_req   <= 1'b1;
          r_mem_we    <= w_gnt_d & d_we;
          r_mem_addr  <= {w_acc_addr[MEMORY_DEPTH-1:2], 2'b00};
          r_mem_be    <= w_be;
          r_mem_wdata <= w_wdata;
        end
      end else if (w_done) begin
        r_mem_req <= 1'b0;
        if (r_state == BUSY_IF) begin
          r_if_rvalid <= 1'b1;
          r_if_err    <= 1'b0;
          r_if_rdata  <= mem_rdata;
        end else begin
          r_d_rvalid <= 1'b1;
          r_d_err    <= 1'b0;
          r_d_rdata  <= r_mem_we ? '0 : w_load;
        end
      end else if (w_timeout) begin
        r_mem_req <= 1'b0;
        if (r_state == BUSY_IF) begin
          r_if_rvalid <= 1'b1;
          r_if_err    <= 1'b1;
          r_if_rdata  <= '0;
        end else begin
          r_d_rvalid <= 1'b1;
          r_d_err    <= 1'b1;
          r_d_rdata  <= '0;
        end
      end else if (r_mem_req) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  // grants are forced low while reset is asserted so every output reads 0
  assign if_ready  = w_gnt_if;
  assign d_ready   = w_gnt_d;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign if_err    = r_if_err;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 32, address width.
REQ-002 SHALL have parameter MEMORY_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum number of wait cycles for mem_ack.
REQ-004 Ports, in this order: clk  in  1  single clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-005 Fetch ports: if_req in 1 request; if_addr in DEPTH word address; if_ready out 1 accept; if_rvalid out 1 response; if_rdata out WIDTH; if_err out 1.
REQ-006 Data ports: d_req in 1; d_we in 1 store; d_width in 2 (1 byte, 2 half, 3 word); d_signed in 1; d_addr in DEPTH; d_wdata in WIDTH.
REQ-007 Data responses: d_ready out 1; d_rvalid out 1; d_rdata out WIDTH; d_err out 1.
REQ-008 Memory ports: mem_req out 1; mem_we out 1; mem_addr out DEPTH word-aligned; mem_be out 4 lane enables; mem_wdata out WIDTH; mem_ack in 1; mem_rdata in WIDTH.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY_IF, BUSY_D and ERR_D.
REQ-010 In IDLE, if_ready and d_ready SHALL be combinational grants; at most one is high per cycle; both are 0 outside IDLE.
REQ-011 Arbitration: a single requester always wins; when both request, the side not granted last wins; the pointer favours data after reset.
REQ-012 On acceptance (req & ready at cycle T), address, we, width, signed, wdata and byte offset SHALL be latched; mem_req SHALL go high at T+1.
REQ-013 mem_req, mem_we, mem_addr, mem_be and mem_wdata SHALL be registered and stable while mem_req=1; mem_ack SHALL be ignored while mem_req=0.
REQ-014 On mem_ack at cycle A: mem_req=0 at A+1; the state returns to IDLE at A+1; the owner's rvalid SHALL pulse for exactly one cycle at A+1.
REQ-015 Latency: minimum 2 cycles from acceptance to rvalid, with mem_ack high at T+1.
REQ-016 A new request may be accepted in the same cycle as the previous rvalid pulse.
REQ-017 mem_addr SHALL be {addr[DEPTH-1:2],2'b00}.
REQ-018 Byte-lane enables: byte -> mem_be = 4'b0001<<off; half -> 4'b0011<<off; word -> 4'b1111; fetch -> 4'b1111 with mem_we=0.
REQ-019 Stores: mem_wdata SHALL be the low byte/half of d_wdata shifted left by 8*off; unused lanes are 0.
REQ-020 Loads: d_rdata SHALL be mem_rdata>>(8*off), truncated to width, then sign-extended if d_signed else zero-extended.
REQ-021 Fetch: if_rdata SHALL be mem_rdata unmodified.
REQ-022 Stores SHALL also pulse d_rvalid on completion, with d_rdata=0.
REQ-023 Illegal data requests SHALL be: d_width=0, half with off[0]=1, or word with off!=0.
REQ-024 An illegal data request SHALL be accepted (d_ready=1), SHALL NOT raise mem_req, SHALL enter ERR_D, and SHALL pulse d_rvalid=1, d_err=1, d_rdata=0 at T+1.
REQ-025 A wait counter SHALL count cycles with mem_req=1 and mem_ack=0.
REQ-026 When the wait counter reaches TIMEOUT: abort, mem_req=0 next cycle, owner rvalid=1 and err=1 with rdata=0, then return to IDLE.
REQ-027 The wait counter SHALL clear on acceptance.
REQ-028 rvalid, err and rdata SHALL be registered outputs; rdata and err hold their value between pulses.
REQ-029 Requests deasserted before acceptance SHALL be dropped without side effects; requesters hold their inputs until ready.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, all outputs 0, the arbitration pointer to favour data, and the wait counter to 0.
REQ-031 Reset mid-transaction SHALL abandon it: mem_req drops immediately, and no rvalid for that transaction ever appears.
REQ-032 Leaving reset, the first grant SHALL be possible in the first clock edge after rst_n rises.

Verification
REQ-033 Fetch if_addr=0x100, mem_ack at T+3, mem_rdata=0xDEADBEEF -> if_rvalid at T+4, if_rdata=0xDEADBEEF, mem_be=4'hF.
REQ-034 Both requesting continuously after reset -> grants alternate D, IF, D, IF; no request starves.
REQ-035 Load byte, signed, d_addr=0x203, mem_rdata=0x80000000 -> mem_addr=0x200, mem_be=4'b1000, d_rdata=0xFFFFFF80; with d_signed=0 -> 0x00000080.
REQ-036 Store half d_addr=0x12, d_wdata=0x1234ABCD -> mem_be=4'b1100, mem_wdata=0xABCD0000, mem_we=1; word store to 0x13 -> no mem_req, d_err=1 at T+1.
REQ-037 TIMEOUT=4, mem_ack held 0 -> mem_req high for 4 cycles, then d_rvalid=1, d_err=1, d_rdata=0, and the FSM is in IDLE.
REQ-038 rst_n pulsed low while in BUSY_D -> mem_req=0 at once, no d_rvalid afterwards, and the next if_req is granted immediately.
